// File: rtl/shift_rows_pipe.sv
// AES ShiftRows / InvShiftRows stage with a 2-entry skid buffer.
// Define SHIFT_ROWS_PIPE_STATS_EN to add block_count and stall_count outputs.
module shift_rows_pipe #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  input  logic                 in_inverse,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic [TAG_WIDTH-1:0] out_tag
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  ,
  output logic [31:0]          block_count,
  output logic [31:0]          stall_count
`endif
);

  typedef struct packed {
    logic [127:0]         data;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  // Byte r+4c sits at bits [127-8(r+4c) -: 8]; row r rotates by r.
  function automatic logic [127:0] shift_rows(
    input logic [127:0] s,
    input logic         inv
  );
    logic [127:0] o;
    logic [1:0]   src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 2'(c - r) : 2'(c + r);
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*int'(src)) -: 8];
      end
    end
    return o;
  endfunction

  entry_t p_q, p_d;
  entry_t s_q, s_d;
  logic   p_valid_q, p_valid_d;
  logic   s_valid_q, s_valid_d;

  logic   accept;
  logic   emit;
  logic   p_free;
  entry_t in_ent;

  assign in_ready  = !s_valid_q && !reset;
  assign out_valid = p_valid_q;
  assign out_data  = p_q.data;
  assign out_tag   = p_q.tag;

  assign accept = in_valid && in_ready;
  assign emit   = p_valid_q && out_ready;
  assign p_free = !p_valid_q || emit;

  always_comb begin
    in_ent.data = shift_rows(in_data, in_inverse);
    in_ent.tag  = in_tag;
  end

  always_comb begin
    p_d       = p_q;
    s_d       = s_q;
    p_valid_d = p_valid_q;
    s_valid_d = s_valid_q;
    if (p_free) begin
      if (s_valid_q) begin
        p_d       = s_q;
        p_valid_d = 1'b1;
        s_valid_d = accept;
        if (accept) begin
          s_d = in_ent;
        end
      end else if (accept) begin
        p_d       = in_ent;
        p_valid_d = 1'b1;
      end else begin
        p_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_ent;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q       <= '0;
      s_q       <= '0;
      p_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      p_q       <= p_d;
      s_q       <= s_d;
      p_valid_q <= p_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

`ifdef SHIFT_ROWS_PIPE_STATS_EN
  logic [31:0] block_count_q, block_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Block count wraps; stall count saturates.
  always_comb begin
    block_count_d = block_count_q + 32'(emit);
    stall_count_d = stall_count_q;
    if (p_valid_q && !out_ready && stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      block_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      block_count_q <= block_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign block_count = block_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Testbench for shift_rows_pipe: vector table, corner sequences, random
// traffic against a queue-based reference model.
module tb_shift_rows_pipe;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inverse;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_tag;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
  logic [31:0]  block_count;
  logic [31:0]  stall_count;
  longint       m_blocks;
  longint       m_stalls;
`endif

  always #5 clock = ~clock;

  shift_rows_pipe #(.TAG_WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inverse (in_inverse),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    ,
    .block_count(block_count),
    .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic [127:0] data;
    logic         inv;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   t;
  } ent_t;

  vec_t tbl[4];
  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: unpack to a 4x4 grid, rotate row r by r single steps.
  function automatic logic [127:0] ref_shift(logic [127:0] d, bit inv);
    logic [7:0]   st[4][4];
    logic [7:0]   t;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[127-8*(r+4*c) -: 8];
    for (int r = 1; r < 4; r++) begin
      for (int k = 0; k < r; k++) begin
        if (!inv) begin
          t = st[r][0];
          st[r][0] = st[r][1];
          st[r][1] = st[r][2];
          st[r][2] = st[r][3];
          st[r][3] = t;
        end else begin
          t = st[r][3];
          st[r][3] = st[r][2];
          st[r][2] = st[r][1];
          st[r][1] = st[r][0];
          st[r][0] = t;
        end
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = st[r][c];
    return o;
  endfunction

  // One clock: predict from the pre-edge inputs, then check after the edge.
  task automatic step();
    bit   em, ac;
    ent_t e;
    em = (q.size() > 0) && out_ready && !reset;
    ac = in_valid && (q.size() < 2) && !reset;
    e.d = ref_shift(in_data, in_inverse);
    e.t = in_tag;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    if (reset) begin
      m_blocks = 0;
      m_stalls = 0;
    end else begin
      if (em) m_blocks++;
      if (q.size() > 0 && !out_ready) m_stalls++;
    end
`endif
    @(posedge clock);
    #1;
    if (reset) q.delete();
    else begin
      if (em) void'(q.pop_front());
      if (ac) q.push_back(e);
    end
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(!reset && q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", 128'(out_tag), 128'(q[0].t));
    end
    if (reset) begin
      chk("rst_out_data", out_data, 128'h0);
      chk("rst_out_tag", 128'(out_tag), 128'h0);
    end
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    chk("block_count", 128'(block_count), 128'(m_blocks[31:0]));
    chk("stall_count", 128'(stall_count), 128'(m_stalls[31:0]));
`endif
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_data    = 'x;
    in_inverse = 1'b0;
    in_tag     = '0;
  endtask

  task automatic drive(logic [127:0] d, logic inv, logic [3:0] t);
    in_valid   = 1'b1;
    in_data    = d;
    in_inverse = inv;
    in_tag     = t;
  endtask

  logic [127:0] held;

  initial begin
    tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd1,
               128'hd4bf5d30e0b452aeb84111f11e2798e5};
    tbl[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'd2,
               128'hd42711aee0bf98f1b8b45de51e415230};
    tbl[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'd3,
               128'h00050a0f04090e03080d02070c01060b};
    tbl[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd14,
               128'h000d0a0704010e0b0805020f0c090603};

    reset     = 1'b1;
    out_ready = 1'b1;
    idle_in();
`ifdef SHIFT_ROWS_PIPE_STATS_EN
    m_blocks = 0;
    m_stalls = 0;
`endif
    step();
    step();
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", 128'(in_ready), 128'h1);
    step();

    // Known-answer table, one block at a time
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].data, tbl[i].inv, tbl[i].tag);
      step();
      chk("tbl_valid", 128'(out_valid), 128'h1);
      chk("tbl_data", out_data, tbl[i].exp);
      chk("tbl_tag", 128'(out_tag), 128'(tbl[i].tag));
      idle_in();
      step();
    end

    // Backpressure: two accepted, third blocked, output held
    out_ready = 1'b0;
    drive(tbl[0].data, 1'b0, 4'd5);
    step();
    held = out_data;
    drive(tbl[2].data, 1'b0, 4'd6);
    step();
    drive(tbl[3].data, 1'b1, 4'd7);
    chk("bp_in_ready_low", 128'(in_ready), 128'h0);
    step();
    chk("bp_hold_data", out_data, held);
    step();
    chk("bp_hold_data2", out_data, held);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle_in();
    for (int i = 0; i < 3; i++) step();
    chk("bp_drained", 128'(out_valid), 128'h0);

    // Streaming with alternating direction
    for (int i = 0; i < 16; i++) begin
      drive({$urandom, $urandom, $urandom, $urandom}, 1'(i), 4'(i));
      step();
      chk("stream_valid", 128'(out_valid), 128'h1);
    end
    idle_in();
    step();
    step();

    // Reset with P and S full and a block offered during reset
    out_ready = 1'b0;
    drive(tbl[0].data, 1'b0, 4'd9);
    step();
    drive(tbl[1].data, 1'b1, 4'd10);
    step();
    reset = 1'b1;
    drive(tbl[2].data, 1'b0, 4'd11);
    #1;
    chk("rst_in_ready_low", 128'(in_ready), 128'h0);
    step();
    reset = 1'b0;
    idle_in();
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready_high", 128'(in_ready), 128'h1);
    step();
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive({$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
              4'($urandom_range(0, 14)));
      else
        idle_in();
      step();
    end
    idle_in();
    out_ready = 1'b1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
